// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline types for the hazard/forwarding logic: in-flight table entry
// and forwarding-select encoding.
package riscv_pipe_pkg;

  // Table entries hold register indices zero-extended to this width.
  localparam int RD_MAX = 8;

  // Forwarding select value that chooses the register file.
  localparam int FWD_RF = 0;

  typedef struct packed {
    logic              valid;
    logic [RD_MAX-1:0] rd;
    logic              regwrite;
    logic              memread;
  } pipe_entry_t;

  // Width of a forwarding select covering the register file plus every post-EX stage.
  function automatic int fwd_width(input int stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Youngest-match priority encoder: returns k+1 for the youngest table position k
// that will write the requested source register, or FWD_RF when nothing matches.
module fwd_select
  import riscv_pipe_pkg::*;
#(
  parameter int RB         = 5,
  parameter int FWD_STAGES = 2,
  localparam int FW        = fwd_width(FWD_STAGES)
) (
  input  logic [RB-1:0] src,
  input  logic          use_src,
  input  pipe_entry_t   tbl [FWD_STAGES],
  output logic [FW-1:0] sel
);

  always_comb begin
    sel = FW'(FWD_RF);
    if (use_src && (src != '0)) begin
      // Scan oldest to youngest so the youngest match is the one that sticks.
      for (int p = FWD_STAGES - 1; p >= 0; p--) begin
        if (tbl[p].valid && tbl[p].regwrite && (tbl[p].rd == RD_MAX'(src))) begin
          sel = FW'(p + 1);
        end
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Load-use stall, branch flush and registered operand-forwarding control, driven
// by a shift table of instructions in flight from EX onward.
module hazard_fwd_unit
  import riscv_pipe_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int RB         = 5,
  parameter int FWD_STAGES = 2,
  parameter int LOAD_LAT   = 1,
  localparam int FW        = fwd_width(FWD_STAGES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [RB-1:0] id_rs1,
  input  logic [RB-1:0] id_rs2,
  input  logic [RB-1:0] id_rd,
  input  logic          id_use_rs1,
  input  logic          id_use_rs2,
  input  logic          id_regwrite,
  input  logic          id_memread,
  input  logic          br_taken,
  output logic          pc_write,
  output logic          if_id_write,
  output logic          control_sel,
  output logic          flush_if_id,
  output logic          flush_id_ex,
  output logic [FW-1:0] forwardA,
  output logic [FW-1:0] forwardB
);

  if (XLEN < 1 || RB < 1 || RB > RD_MAX || FWD_STAGES < 2 || FWD_STAGES > 4 ||
      LOAD_LAT < 1 || LOAD_LAT > 2) begin : g_bad_params
    $error("hazard_fwd_unit: parameter out of range");
  end

  pipe_entry_t   tbl_reg  [FWD_STAGES+1];
  pipe_entry_t   tbl_next [FWD_STAGES+1];
  pipe_entry_t   fwd_view [FWD_STAGES];
  pipe_entry_t   id_entry;
  logic          load_hit;
  logic          stall;
  logic          flush;
  logic [FW-1:0] sel_a;
  logic [FW-1:0] sel_b;
  logic [FW-1:0] fwd_a_reg;
  logic [FW-1:0] fwd_b_reg;

  always_comb begin
    id_entry          = '0;
    id_entry.valid    = id_valid;
    id_entry.rd       = RD_MAX'(id_rd);
    id_entry.regwrite = id_regwrite;
    id_entry.memread  = id_memread;
  end

  // Load-use: a consumed, nonzero source still waiting on a load in the stall window.
  always_comb begin
    load_hit = 1'b0;
    for (int p = 0; p < LOAD_LAT; p++) begin
      if (tbl_reg[p].valid && tbl_reg[p].memread) begin
        if ((id_use_rs1 && (id_rs1 != '0) && (tbl_reg[p].rd == RD_MAX'(id_rs1))) ||
            (id_use_rs2 && (id_rs2 != '0) && (tbl_reg[p].rd == RD_MAX'(id_rs2)))) begin
          load_hit = 1'b1;
        end
      end
    end
  end

  // A taken branch wins over a stall; reset suppresses both.
  assign flush = reset && br_taken;
  assign stall = reset && !br_taken && id_valid && load_hit;

  assign pc_write    = !stall;
  assign if_id_write = !stall;
  assign control_sel = stall || flush;
  assign flush_if_id = flush;
  assign flush_id_ex = flush;

  always_comb begin
    tbl_next[0] = (stall || flush) ? '0 : id_entry;
    for (int p = 1; p <= FWD_STAGES; p++) begin
      tbl_next[p] = tbl_reg[p-1];
    end
    for (int p = 0; p < FWD_STAGES; p++) begin
      fwd_view[p] = tbl_reg[p];
    end
  end

  fwd_select #(.RB(RB), .FWD_STAGES(FWD_STAGES)) u_fwd_rs1 (
    .src     (id_rs1),
    .use_src (id_use_rs1),
    .tbl     (fwd_view),
    .sel     (sel_a)
  );

  fwd_select #(.RB(RB), .FWD_STAGES(FWD_STAGES)) u_fwd_rs2 (
    .src     (id_rs2),
    .use_src (id_use_rs2),
    .tbl     (fwd_view),
    .sel     (sel_b)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int p = 0; p <= FWD_STAGES; p++) begin
        tbl_reg[p] <= '0;
      end
      fwd_a_reg <= FW'(FWD_RF);
      fwd_b_reg <= FW'(FWD_RF);
    end else begin
      tbl_reg <= tbl_next;
      if (stall || flush) begin
        fwd_a_reg <= FW'(FWD_RF);
        fwd_b_reg <= FW'(FWD_RF);
      end else begin
        fwd_a_reg <= sel_a;
        fwd_b_reg <= sel_b;
      end
    end
  end

  assign forwardA = fwd_a_reg;
  assign forwardB = fwd_b_reg;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed checks of hazard_fwd_unit: instance 0 uses FWD_STAGES=2/LOAD_LAT=1,
// instance 1 uses FWD_STAGES=3/LOAD_LAT=2.
module tb_hazard_fwd_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid    [2];
  logic [4:0] id_rs1      [2];
  logic [4:0] id_rs2      [2];
  logic [4:0] id_rd       [2];
  logic       id_use_rs1  [2];
  logic       id_use_rs2  [2];
  logic       id_regwrite [2];
  logic       id_memread  [2];
  logic       br_taken    [2];

  logic       pc_write_0, if_id_write_0, control_sel_0, flush_if_id_0, flush_id_ex_0;
  logic       pc_write_1, if_id_write_1, control_sel_1, flush_if_id_1, flush_id_ex_1;
  logic [1:0] fwd_a_0, fwd_b_0, fwd_a_1, fwd_b_1;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  hazard_fwd_unit #(.XLEN(32), .RB(5), .FWD_STAGES(2), .LOAD_LAT(1)) dut0 (
    .clk(clk), .reset(reset), .id_valid(id_valid[0]), .id_rs1(id_rs1[0]), .id_rs2(id_rs2[0]),
    .id_rd(id_rd[0]), .id_use_rs1(id_use_rs1[0]), .id_use_rs2(id_use_rs2[0]),
    .id_regwrite(id_regwrite[0]), .id_memread(id_memread[0]), .br_taken(br_taken[0]),
    .pc_write(pc_write_0), .if_id_write(if_id_write_0), .control_sel(control_sel_0),
    .flush_if_id(flush_if_id_0), .flush_id_ex(flush_id_ex_0),
    .forwardA(fwd_a_0), .forwardB(fwd_b_0)
  );

  hazard_fwd_unit #(.XLEN(32), .RB(5), .FWD_STAGES(3), .LOAD_LAT(2)) dut1 (
    .clk(clk), .reset(reset), .id_valid(id_valid[1]), .id_rs1(id_rs1[1]), .id_rs2(id_rs2[1]),
    .id_rd(id_rd[1]), .id_use_rs1(id_use_rs1[1]), .id_use_rs2(id_use_rs2[1]),
    .id_regwrite(id_regwrite[1]), .id_memread(id_memread[1]), .br_taken(br_taken[1]),
    .pc_write(pc_write_1), .if_id_write(if_id_write_1), .control_sel(control_sel_1),
    .flush_if_id(flush_if_id_1), .flush_id_ex(flush_id_ex_1),
    .forwardA(fwd_a_1), .forwardB(fwd_b_1)
  );

  task automatic chk(input string tag, input int got, input int exp);
    vec_cnt++;
    if (got != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("  ok %s = %0d", tag, got);
    end
  endtask

  task automatic chk_ctl(input string tag, input int d, input int pc, input int ifid,
                         input int cs, input int fl);
    if (d == 0) begin
      chk({tag, ".pc_write"},    int'(pc_write_0),    pc);
      chk({tag, ".if_id_write"}, int'(if_id_write_0), ifid);
      chk({tag, ".control_sel"}, int'(control_sel_0), cs);
      chk({tag, ".flush_if_id"}, int'(flush_if_id_0), fl);
      chk({tag, ".flush_id_ex"}, int'(flush_id_ex_0), fl);
    end else begin
      chk({tag, ".pc_write"},    int'(pc_write_1),    pc);
      chk({tag, ".if_id_write"}, int'(if_id_write_1), ifid);
      chk({tag, ".control_sel"}, int'(control_sel_1), cs);
      chk({tag, ".flush_if_id"}, int'(flush_if_id_1), fl);
      chk({tag, ".flush_id_ex"}, int'(flush_id_ex_1), fl);
    end
  endtask

  task automatic chk_fwd(input string tag, input int d, input int a, input int b);
    if (d == 0) begin
      chk({tag, ".forwardA"}, int'(fwd_a_0), a);
      chk({tag, ".forwardB"}, int'(fwd_b_0), b);
    end else begin
      chk({tag, ".forwardA"}, int'(fwd_a_1), a);
      chk({tag, ".forwardB"}, int'(fwd_b_1), b);
    end
  endtask

  task automatic set_id(input int d, input bit v, input int rs1, input int rs2, input int rd,
                        input bit u1, input bit u2, input bit rw, input bit mr);
    id_valid[d]    = v;
    id_rs1[d]      = 5'(rs1);
    id_rs2[d]      = 5'(rs2);
    id_rd[d]       = 5'(rd);
    id_use_rs1[d]  = u1;
    id_use_rs2[d]  = u2;
    id_regwrite[d] = rw;
    id_memread[d]  = mr;
    br_taken[d]    = 1'b0;
  endtask

  task automatic idle(input int d);
    set_id(d, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int d);
    idle(d);
    repeat (4) tick();
  endtask

  // Instruction shorthands: load x5 <- [x2], add x6 = x5 + x1.
  task automatic load_x5(input int d);
    set_id(d, 1'b1, 2, 0, 5, 1'b1, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic add_x6_x5_x1(input int d);
    set_id(d, 1'b1, 5, 1, 6, 1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    idle(0);
    idle(1);
    // Make a load-use candidate visible in ID while reset is held.
    add_x6_x5_x1(0);
    tick();
    tick();
    chk_ctl("reset0", 0, 1, 1, 0, 0);
    chk_fwd("reset0", 0, 0, 0);
    chk_ctl("reset1", 1, 1, 1, 0, 0);
    chk_fwd("reset1", 1, 0, 0);
    reset = 1'b1;
    idle(0);

    // Load-use with a one-cycle stall window, then forward from WB.
    load_x5(0);
    #1 chk_ctl("ld_issue", 0, 1, 1, 0, 0);
    tick();
    add_x6_x5_x1(0);
    #1 chk_ctl("lu_stall", 0, 0, 0, 1, 0);
    tick();
    chk_fwd("lu_bubble", 0, 0, 0);
    #1 chk_ctl("lu_release", 0, 1, 1, 0, 0);
    tick();
    chk_fwd("lu_fwd_wb", 0, 2, 0);
    drain(0);

    // add x3; sub x3; or x7,x3,x3 -> youngest producer (MEM) on both operands.
    set_id(0, 1'b1, 1, 2, 3, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(0, 1'b1, 4, 5, 3, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(0, 1'b1, 3, 3, 7, 1'b1, 1'b1, 1'b1, 1'b0);
    #1 chk_ctl("alu_nostall", 0, 1, 1, 0, 0);
    tick();
    chk_fwd("youngest_mem", 0, 1, 1);
    drain(0);

    // Producer two ahead -> WB forward; rs2 also names x3 but is not read.
    set_id(0, 1'b1, 1, 2, 3, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    idle(0);
    tick();
    set_id(0, 1'b1, 3, 3, 8, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    chk_fwd("wb_unused_src", 0, 2, 0);
    drain(0);

    // Load into x0 then read x0 twice: never stalls, never forwards.
    set_id(0, 1'b1, 1, 2, 0, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    set_id(0, 1'b1, 0, 0, 8, 1'b1, 1'b1, 1'b1, 1'b0);
    #1 chk_ctl("x0_nostall", 0, 1, 1, 0, 0);
    tick();
    chk_fwd("x0_nofwd", 0, 0, 0);
    drain(0);

    // Taken branch coincident with a load-use match: flush wins.
    load_x5(0);
    tick();
    set_id(0, 1'b1, 5, 1, 9, 1'b1, 1'b1, 1'b1, 1'b0);
    br_taken[0] = 1'b1;
    #1 chk_ctl("br_flush", 0, 1, 1, 1, 1);
    tick();
    chk_fwd("br_sel_zero", 0, 0, 0);
    set_id(0, 1'b1, 9, 5, 10, 1'b1, 1'b1, 1'b1, 1'b0);
    #1 chk_ctl("br_after", 0, 1, 1, 0, 0);
    tick();
    chk_fwd("br_ex_invalid", 0, 0, 2);
    drain(0);

    // Two-cycle load-use window, forward from stage 3.
    load_x5(1);
    #1 chk_ctl("ll2_issue", 1, 1, 1, 0, 0);
    tick();
    add_x6_x5_x1(1);
    #1 chk_ctl("ll2_stall1", 1, 0, 0, 1, 0);
    tick();
    chk_fwd("ll2_bubble1", 1, 0, 0);
    #1 chk_ctl("ll2_stall2", 1, 0, 0, 1, 0);
    tick();
    chk_fwd("ll2_bubble2", 1, 0, 0);
    #1 chk_ctl("ll2_release", 1, 1, 1, 0, 0);
    tick();
    chk_fwd("ll2_fwd3", 1, 3, 0);
    drain(1);

    // Reset during the second stall cycle aborts the stall and empties the table.
    load_x5(1);
    tick();
    add_x6_x5_x1(1);
    #1 chk_ctl("rst_stall1", 1, 0, 0, 1, 0);
    tick();
    #1 chk_ctl("rst_stall2", 1, 0, 0, 1, 0);
    reset = 1'b0;
    #1 chk_ctl("rst_mid", 1, 1, 1, 0, 0);
    tick();
    chk_fwd("rst_fwd", 1, 0, 0);
    reset = 1'b1;
    #1 chk_ctl("rst_nostall", 1, 1, 1, 0, 0);
    tick();
    chk_fwd("rst_empty", 1, 0, 0);
    drain(1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
